// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and 12-bit frame-buffer colour helpers.
package vga_pkg;

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] H_FP     = 10'd16;
  localparam logic [9:0] H_SYNC   = 10'd96;
  localparam logic [9:0] H_TOTAL  = 10'd800;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] V_FP     = 10'd10;
  localparam logic [9:0] V_SYNC   = 10'd2;
  localparam logic [9:0] V_TOTAL  = 10'd525;

  localparam logic [9:0] H_LAST       = H_TOTAL - 10'd1;
  localparam logic [9:0] V_LAST       = V_TOTAL - 10'd1;
  localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FP;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FP;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef logic [11:0] color12_t;

  // Keep the top nibble of each 8-bit channel.
  function automatic color12_t pack_color(input logic [23:0] c);
    return {c[23:20], c[15:12], c[7:4]};
  endfunction

  function automatic logic [7:0] widen_nibble(input logic [3:0] nib);
    return {nib, nib};
  endfunction

endpackage

// File: rtl/frame_buffer.sv
// Simple dual-port frame buffer: one write port, one registered read port.
module frame_buffer #(
  parameter int    n         = 12,
  parameter int    Mn        = 15,
  parameter int    DEPTH     = 1 << Mn,
  parameter string INIT_FILE = "black.mif"
) (
  input  logic          CLOCK_50,
  input  logic          wr_en,
  input  logic [Mn-1:0] wr_addr,
  input  logic [n-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [Mn-1:0] rd_addr,
  output logic [n-1:0]  rd_data
);

  logic [n-1:0] mem [0:DEPTH-1];

  // Read sees the pre-write word when both ports hit one address in a cycle.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vga_scanout.sv
// Pixel-plot frame buffer with 640x480 VGA scan-out; low-res buffers are pixel-replicated.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int    COLS      = 160,
  parameter int    ROWS      = 120,
  parameter int    nX        = 8,
  parameter int    nY        = 7,
  parameter int    Mn        = 15,
  parameter string INIT_FILE = "black.mif"
) (
  input  logic          CLOCK_50,
  input  logic          Resetn,
  input  logic [nX-1:0] VGA_X,
  input  logic [nY-1:0] VGA_Y,
  input  logic [23:0]   VGA_COLOR,
  input  logic          plot,
  output logic [7:0]    VGA_R,
  output logic [7:0]    VGA_G,
  output logic [7:0]    VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK_N,
  output logic          VGA_SYNC_N,
  output logic          VGA_CLK
);

  // COLS = 5 * 2^COL_SH, so y*COLS = (y << COL_SH+2) + (y << COL_SH).
  localparam int SCALE_SH = $clog2(640 / COLS);
  localparam int COL_SH   = $clog2(COLS / 5);

  logic          pix_en;
  logic [9:0]    hcount, vcount;
  logic          active, hs_zone, vs_zone;
  logic          active_d1, hs_d1, vs_d1;
  logic [Mn-1:0] wr_row, wr_col, wr_addr;
  logic [Mn-1:0] rd_row, rd_col, rd_addr;
  logic          wr_en;
  color12_t      rd_data;

  // plot is a fire-and-forget strobe: no ready, every in-range cycle is a write.
  assign wr_row  = Mn'(VGA_Y);
  assign wr_col  = Mn'(VGA_X);
  assign wr_addr = (wr_row << (COL_SH + 2)) + (wr_row << COL_SH) + wr_col;
  assign wr_en   = Resetn & plot & (32'(VGA_X) < COLS) & (32'(VGA_Y) < ROWS);

  assign rd_row  = Mn'(vcount >> SCALE_SH);
  assign rd_col  = Mn'(hcount >> SCALE_SH);
  assign rd_addr = (rd_row << (COL_SH + 2)) + (rd_row << COL_SH) + rd_col;

  assign active  = (hcount < H_ACTIVE) && (vcount < V_ACTIVE);
  assign hs_zone = (hcount >= H_SYNC_START) && (hcount < H_SYNC_END);
  assign vs_zone = (vcount >= V_SYNC_START) && (vcount < V_SYNC_END);

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      pix_en <= 1'b0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (hcount == H_LAST) begin
          hcount <= '0;
          vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
        end else begin
          hcount <= hcount + 10'd1;
        end
      end
    end
  end

  frame_buffer #(
    .n        (12),
    .Mn       (Mn),
    .DEPTH    (ROWS * COLS),
    .INIT_FILE(INIT_FILE)
  ) u_frame_buffer (
    .CLOCK_50(CLOCK_50),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (pack_color(VGA_COLOR)),
    .rd_en   (pix_en & active),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Stage 1 sits beside the buffer read; stage 2 drives the pins, two ticks after the counters.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      active_d1   <= 1'b0;
      hs_d1       <= 1'b1;
      vs_d1       <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_R       <= 8'h00;
      VGA_G       <= 8'h00;
      VGA_B       <= 8'h00;
    end else if (pix_en) begin
      active_d1   <= active;
      hs_d1       <= ~hs_zone;
      vs_d1       <= ~vs_zone;
      VGA_BLANK_N <= active_d1;
      VGA_HS      <= hs_d1;
      VGA_VS      <= vs_d1;
      VGA_R       <= active_d1 ? widen_nibble(rd_data[11:8]) : 8'h00;
      VGA_G       <= active_d1 ? widen_nibble(rd_data[7:4])  : 8'h00;
      VGA_B       <= active_d1 ? widen_nibble(rd_data[3:0])  : 8'h00;
    end
  end

  assign VGA_CLK    = pix_en;
  assign VGA_SYNC_N = 1'b0;

endmodule
